// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/issue stage.
//   - Instruction layout: op=[8:6], rs=[5:3], rt=[2:0].
//   - opcode_e   : the eight opcodes.
//   - decoded_t  : register-file controls produced for one instruction.
//   - decode()   : combinational instruction decoder with index range check.
package isa_pkg;

    localparam int IW       = 9;
    localparam int RW       = 3;
    localparam int NUM_REGS = 6;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 3;
    localparam int RT_HI = 2;
    localparam int RT_LO = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_MOV = 3'd3,
        OP_LBL = 3'd4,
        OP_JMP = 3'd5,
        OP_LD  = 3'd6,
        OP_ST  = 3'd7
    } opcode_e;

    typedef struct packed {
        opcode_e         op;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic            reg_write;
        logic            label_write;
        logic            label_read;
        logic            illegal;
    } decoded_t;

    // Fields not driven by an opcode (rd of JMP/ST) stay 0.
    // An out-of-range index marks the instruction illegal and strips its
    // writes; source indices and label_read are still reported as decoded.
    function automatic decoded_t decode(input logic [IW-1:0] instr,
                                        input int            num_regs);
        decoded_t      d;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          use_rs;
        logic          bad;

        rs     = instr[RS_HI:RS_LO];
        rt     = instr[RT_HI:RT_LO];
        d      = '0;
        d.op   = opcode_e'(instr[OP_HI:OP_LO]);
        use_rs = 1'b1;

        case (d.op)
            OP_ADD, OP_SUB, OP_AND: begin
                d.rs1       = rs;
                d.rs2       = rt;
                d.rd        = rs;
                d.reg_write = 1'b1;
            end
            OP_MOV, OP_LD: begin
                d.rs1       = rt;
                d.rs2       = rt;
                d.rd        = rs;
                d.reg_write = 1'b1;
            end
            OP_LBL: begin
                d.rs1         = rt;
                d.rs2         = rt;
                d.rd          = rs;
                d.label_write = 1'b1;
            end
            OP_JMP: begin
                d.rs1        = rt;
                d.rs2        = rt;
                d.label_read = 1'b1;
                use_rs       = 1'b0;   // JMP has no rs operand
            end
            OP_ST: begin
                d.rs1 = rs;
                d.rs2 = rt;
            end
            default: ;
        endcase

        bad = (int'(rt) >= num_regs) || (use_rs && (int'(rs) >= num_regs));
        if (bad) begin
            d.illegal     = 1'b1;
            d.reg_write   = 1'b0;
            d.label_write = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_stage_scoreboard.sv
// Pending-write scoreboard for the general and label register banks.
//   clk, rst_n                     : clock, async active-low reset
//   src1, src2, src_label          : source indices and the bank they read
//   dst, dst_write, dst_label      : destination of the candidate instruction
//   set_en                         : candidate accepted; mark dst busy
//   wb_valid, wb_rd, wb_label      : writeback retiring a write (clears busy)
//   flush_clr, flush_rd, flush_label : discarded entry's write is cancelled
//   hazard                         : candidate must stall (RAW or WAW)
module decode_issue_stage_scoreboard #(
    parameter int NUM_REGS = 6,
    parameter int RW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] src1,
    input  logic [RW-1:0] src2,
    input  logic          src_label,
    input  logic [RW-1:0] dst,
    input  logic          dst_write,
    input  logic          dst_label,
    input  logic          set_en,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_label,
    input  logic          flush_clr,
    input  logic [RW-1:0] flush_rd,
    input  logic          flush_label,
    output logic          hazard
);

    // Out-of-range indices decode to an all-zero vector, so they never hit
    // a busy bit and a writeback to them is ignored.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == RW'(i));
        end
        return oh;
    endfunction

    logic [NUM_REGS-1:0] busy_g, busy_l;
    logic [NUM_REGS-1:0] wb_clr_g, wb_clr_l;
    logic [NUM_REGS-1:0] fl_clr_g, fl_clr_l;
    logic [NUM_REGS-1:0] set_g, set_l;
    logic [NUM_REGS-1:0] eff_g, eff_l;
    logic [NUM_REGS-1:0] src_bank, dst_bank;
    logic [NUM_REGS-1:0] wb_oh, fl_oh, set_oh;

    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment) so no latch is inferred.
    always_comb begin
        wb_oh    = wb_valid  ? onehot(wb_rd)    : '0;
        fl_oh    = flush_clr ? onehot(flush_rd) : '0;
        set_oh   = set_en    ? onehot(dst)      : '0;

        wb_clr_g = wb_label    ? '0 : wb_oh;
        wb_clr_l = wb_label    ? wb_oh : '0;
        fl_clr_g = flush_label ? '0 : fl_oh;
        fl_clr_l = flush_label ? fl_oh : '0;
        set_g    = dst_label   ? '0 : set_oh;
        set_l    = dst_label   ? set_oh : '0;

        // A write retiring this cycle no longer blocks anyone.
        eff_g    = busy_g & ~wb_clr_g;
        eff_l    = busy_l & ~wb_clr_l;

        src_bank = src_label ? eff_l : eff_g;
        dst_bank = dst_label ? eff_l : eff_g;

        hazard   = (|((onehot(src1) | onehot(src2)) & src_bank)) ||
                   (dst_write && (|(onehot(dst) & dst_bank)));
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the busy vectors are control state and must come out of reset
    // cleared; nothing here is a RAM that could skip reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_g <= '0;
            busy_l <= '0;
        end else begin
            // Set is OR-ed last so it wins over a same-cycle clear.
            busy_g <= (busy_g & ~wb_clr_g & ~fl_clr_g) | set_g;
            busy_l <= (busy_l & ~wb_clr_l & ~fl_clr_l) | set_l;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage feeding the register file.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready/in_instr : instruction handshake from fetch
//   out_valid/out_ready        : one-entry decoded output register handshake
//   out_op .. out_illegal      : decoded register-file controls
//   wb_valid, wb_rd, wb_label  : writeback retiring a write
//   flush                      : discard the held output entry
module decode_issue_stage
    import isa_pkg::*;
#(
    parameter int NUM_REGS = isa_pkg::NUM_REGS,
    parameter int IW       = isa_pkg::IW,
    parameter int RW       = isa_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [RW-1:0] out_rs1,
    output logic [RW-1:0] out_rs2,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_label_write,
    output logic          out_label_read,
    output logic          out_illegal,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_label,
    input  logic          flush
);

    decoded_t dec;
    decoded_t out_q;
    logic     out_valid_q;
    logic     hazard;
    logic     accept;
    logic     dec_writes;
    logic     out_writes;

    assign dec        = decode(in_instr, NUM_REGS);
    assign dec_writes = dec.reg_write | dec.label_write;
    assign out_writes = out_q.reg_write | out_q.label_write;

    // The slot is free when empty or being drained; flush blocks intake so
    // the discarded entry's busy clear cannot race a new set.
    assign in_ready = rst_n & ~hazard & (~out_valid_q | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    decode_issue_stage_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .RW       (RW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .src1        (dec.rs1),
        .src2        (dec.rs2),
        .src_label   (dec.label_read),
        .dst         (dec.rd),
        .dst_write   (dec_writes),
        .dst_label   (dec.label_write),
        .set_en      (accept & dec_writes),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_label    (wb_label),
        .flush_clr   (flush & out_valid_q & out_writes),
        .flush_rd    (out_q.rd),
        .flush_label (out_q.label_write),
        .hazard      (hazard)
    );

    // Flush takes priority over out_ready: a flushed entry is never
    // treated as consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_op          = out_q.op;
    assign out_rs1         = out_q.rs1;
    assign out_rs2         = out_q.rs2;
    assign out_rd          = out_q.rd;
    assign out_reg_write   = out_q.reg_write;
    assign out_label_write = out_q.label_write;
    assign out_label_read  = out_q.label_read;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: a cycle-by-cycle vector table
// (inputs for the cycle, expected in_ready in that cycle, expected registered
// outputs in that cycle) followed by a hand-written mid-stream reset sequence.
module tb_decode_issue_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_instr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_op;
    logic [2:0] out_rs1;
    logic [2:0] out_rs2;
    logic [2:0] out_rd;
    logic       out_reg_write;
    logic       out_label_write;
    logic       out_label_read;
    logic       out_illegal;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic       wb_label;
    logic       flush;

    int checks = 0;
    int errors = 0;

    decode_issue_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_op          (out_op),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_label_write (out_label_write),
        .out_label_read  (out_label_read),
        .out_illegal     (out_illegal),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_label        (wb_label),
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field vector layout: op[15:13] rs1[12:10] rs2[9:7] rd[6:4]
    //                      reg_write[3] label_write[2] label_read[1] illegal[0]
    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_NO_RD = 16'hFF8F;

    typedef struct {
        logic        iv;
        logic [8:0]  instr;
        logic        ordy;
        logic        wbv;
        logic [2:0]  wbrd;
        logic        wbl;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_f;
        logic [15:0] e_m;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] fld(input logic [2:0] op, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [2:0] rd,
                                        input logic rw, input logic lw,
                                        input logic lr, input logic il);
        return {op, rs1, rs2, rd, rw, lw, lr, il};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [8:0] instr,
                                input logic ordy, input logic wbv,
                                input logic [2:0] wbrd, input logic wbl,
                                input logic fl, input logic e_ir,
                                input logic e_ov, input logic [15:0] e_f,
                                input logic [15:0] e_m);
        vec_t v;
        v.iv = iv; v.instr = instr; v.ordy = ordy; v.wbv = wbv; v.wbrd = wbrd;
        v.wbl = wbl; v.fl = fl; v.e_ir = e_ir; v.e_ov = e_ov; v.e_f = e_f;
        v.e_m = e_m;
        return v;
    endfunction

    function automatic logic [15:0] dut_fields();
        return {out_op, out_rs1, out_rs2, out_rd, out_reg_write,
                out_label_write, out_label_read, out_illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [8:0] instr,
                         input logic ordy, input logic wbv,
                         input logic [2:0] wbrd, input logic wbl,
                         input logic fl);
        in_valid  = iv;
        in_instr  = instr;
        out_ready = ordy;
        wb_valid  = wbv;
        wb_rd     = wbrd;
        wb_label  = wbl;
        flush     = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run is a fixed number of cycles, this only guards
    // against a broken simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ADD a0,a1=0x001  SUB a1,a0=0x048  LBL l3,a1=0x119  JMP l3=0x143
        // illegal ADD rs=7=0x038  ADD a2,a3=0x013  AND a3,a1=0x099
        // LD a1,a0=0x188  ADD a2,a0=0x010  MOV a1,a2=0x0CA  ST a2,a2=0x1D2
        // ADD a1,a0=0x008  JMP rt=6 (illegal)=0x146
        //             iv instr  ordy wbv wbrd wbl fl  ir  ov  fields                               mask
        vecs.push_back(mk(1, 9'h001, 1, 0, 0, 0, 0, 1, 0, 16'h0, M_ALL));                             // 0 accept ADD
        vecs.push_back(mk(1, 9'h048, 1, 0, 0, 0, 0, 0, 1, fld(0,0,1,0,1,0,0,0), M_ALL));              // 1 RAW on a0
        vecs.push_back(mk(1, 9'h048, 1, 0, 0, 0, 0, 0, 0, 16'h0, M_ALL));                             // 2 still stalled
        vecs.push_back(mk(1, 9'h048, 1, 1, 0, 0, 0, 1, 0, 16'h0, M_ALL));                             // 3 wb a0 bypass
        vecs.push_back(mk(1, 9'h119, 1, 1, 1, 0, 0, 1, 1, fld(1,1,0,1,1,0,0,0), M_ALL));              // 4 LBL, wb a1
        vecs.push_back(mk(1, 9'h143, 1, 0, 0, 0, 0, 0, 1, fld(4,1,1,3,0,1,0,0), M_ALL));              // 5 JMP stalls l3
        vecs.push_back(mk(1, 9'h143, 1, 1, 3, 0, 0, 0, 0, 16'h0, M_ALL));                             // 6 wrong-bank wb
        vecs.push_back(mk(1, 9'h143, 1, 1, 3, 1, 0, 1, 0, 16'h0, M_ALL));                             // 7 wb l3 bypass
        vecs.push_back(mk(1, 9'h038, 1, 0, 0, 0, 0, 1, 1, fld(5,3,3,0,0,0,1,0), M_NO_RD));            // 8 illegal in
        vecs.push_back(mk(1, 9'h013, 1, 0, 0, 0, 0, 1, 1, fld(0,7,0,7,0,0,0,1), M_ALL));              // 9 next not stalled
        vecs.push_back(mk(1, 9'h099, 0, 1, 6, 0, 0, 0, 1, fld(0,2,3,2,1,0,0,0), M_ALL));              // 10 hold 1, wb rd=6
        vecs.push_back(mk(1, 9'h099, 0, 0, 0, 0, 0, 0, 1, fld(0,2,3,2,1,0,0,0), M_ALL));              // 11 hold 2
        vecs.push_back(mk(1, 9'h099, 0, 0, 0, 0, 0, 0, 1, fld(0,2,3,2,1,0,0,0), M_ALL));              // 12 hold 3
        vecs.push_back(mk(1, 9'h099, 1, 0, 0, 0, 0, 1, 1, fld(0,2,3,2,1,0,0,0), M_ALL));              // 13 release
        vecs.push_back(mk(1, 9'h188, 1, 0, 0, 0, 0, 1, 1, fld(2,3,1,3,1,0,0,0), M_ALL));              // 14 back-to-back
        vecs.push_back(mk(0, 9'h000, 1, 1, 2, 0, 0, 1, 1, fld(6,0,0,1,1,0,0,0), M_ALL));              // 15 wb a2
        vecs.push_back(mk(1, 9'h010, 1, 0, 0, 0, 0, 1, 0, 16'h0, M_ALL));                             // 16 accept ADD a2
        vecs.push_back(mk(1, 9'h0CA, 1, 0, 0, 0, 1, 0, 1, fld(0,2,0,2,1,0,0,0), M_ALL));              // 17 flush+ready
        vecs.push_back(mk(1, 9'h1D2, 1, 0, 0, 0, 0, 1, 0, 16'h0, M_ALL));                             // 18 a2 free again
        vecs.push_back(mk(1, 9'h0CA, 1, 0, 0, 0, 0, 0, 1, fld(7,2,2,0,0,0,0,0), M_NO_RD));            // 19 WAW on a1
        vecs.push_back(mk(1, 9'h0CA, 1, 1, 1, 0, 0, 1, 0, 16'h0, M_ALL));                             // 20 wb a1, set a1
        vecs.push_back(mk(1, 9'h008, 1, 0, 0, 0, 0, 0, 1, fld(3,2,2,1,1,0,0,0), M_ALL));              // 21 set won
        vecs.push_back(mk(1, 9'h008, 1, 1, 1, 0, 0, 1, 0, 16'h0, M_ALL));                             // 22 wb a1 bypass
        vecs.push_back(mk(1, 9'h146, 1, 1, 1, 0, 0, 1, 1, fld(0,1,0,1,1,0,0,0), M_ALL));              // 23 illegal JMP
        vecs.push_back(mk(0, 9'h000, 1, 1, 3, 0, 0, 1, 1, fld(5,6,6,0,0,0,1,1), M_NO_RD));            // 24 drain
        vecs.push_back(mk(0, 9'h000, 1, 0, 0, 0, 0, 1, 0, 16'h0, M_ALL));                             // 25 idle

        // Reset state.
        rst_n = 1'b0;
        drive(0, 9'h000, 1, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset fields",    32'(dut_fields()), 32'd0);
        check("reset in_ready",  32'(in_ready), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].ordy, vecs[i].wbv,
                  vecs[i].wbrd, vecs[i].wbl, vecs[i].fl);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d fields", i),
                      32'(dut_fields() & vecs[i].e_m),
                      32'(vecs[i].e_f & vecs[i].e_m));
            end
            next_cycle();
        end

        // Mid-stream reset with an entry held and busy_g[2] set.
        drive(1, 9'h010, 0, 0, 0, 0, 0);
        #1;
        check("pre-reset accept in_ready", 32'(in_ready), 32'd1);
        next_cycle();
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        drive(0, 9'h000, 0, 0, 0, 0, 0);
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset fields",    32'(dut_fields()), 32'd0);
        check("async reset in_ready",  32'(in_ready), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1, 9'h010, 1, 0, 0, 0, 0);
        #1;
        check("post-reset ADD a2 in_ready", 32'(in_ready), 32'd1);
        next_cycle();
        drive(0, 9'h000, 1, 0, 0, 0, 0);
        #1;
        check("post-reset out_valid", 32'(out_valid), 32'd1);
        check("post-reset fields", 32'(dut_fields()), 32'(fld(0,2,0,2,1,0,0,0)));
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/issue stage directly upstream of the register file.
- Accepts 9-bit instructions from fetch over a valid/ready handshake and decodes them into register-file read/write controls (rs1, rs2, rd, reg_write, label_write, label_read).
- Holds each decoded instruction in a one-entry output register and stalls on RAW/WAW hazards, tracked by a pending-write scoreboard that the writeback stage clears.

Parameters:
NUM_REGS, 6, implemented registers per bank (general a0-a3/v0/c0, label l0-l5); indices >= NUM_REGS are illegal
IW, 9, instruction width
RW, 3, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  IW  instruction; op=[8:6], rs=[5:3], rt=[2:0]
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream (register-file read/execute) consumes entry
out_op  out  3  opcode
out_rs1  out  RW  register-file read index A
out_rs2  out  RW  register-file read index B
out_rd  out  RW  destination index
out_reg_write  out  1  writes general bank
out_label_write  out  1  writes label bank
out_label_read  out  1  reads come from label bank
out_illegal  out  1  index out of range; entry carries no writes
wb_valid  in  1  writeback retiring a write
wb_rd  in  RW  retiring destination
wb_label  in  1  retiring write targets label bank
flush  in  1  discard output entry (branch taken)

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* fields=0; both busy vectors=0. in_ready is 0 while in reset.
- Decode, by op:
  - 0 ADD, 1 SUB, 2 AND: rs1=rs, rs2=rt, rd=rs, reg_write.
  - 3 MOV: rs1=rt, rs2=rt, rd=rs, reg_write.
  - 4 LBL: rs1=rt, rs2=rt, rd=rs, label_write.
  - 5 JMP: rs1=rt, rs2=rt, label_read, no write.
  - 6 LD: rs1=rt, rs2=rt, rd=rs, reg_write.
  - 7 ST: rs1=rs, rs2=rt, no write.
- Illegal: any used index >= NUM_REGS -> out_illegal=1, write flags forced 0, no busy bit set.
- Scoreboard:
  - busy_g[NUM_REGS] and busy_l[NUM_REGS].
  - Sources check the bank selected by label_read; destination checks busy of its own bank.
  - Effective busy = busy & ~(wb clear this cycle): same-cycle writeback bypasses the stall.
- Hazard: any source or destination effectively busy -> stall.
- in_ready = rst_n & ~hazard & (~out_valid | out_ready) & ~flush.
- Accept (in_valid & in_ready): decoded fields registered next edge, out_valid=1, busy[rd] set if the instruction writes.
- Latency: 1 cycle from accept to out_valid. Full throughput when no hazards.
- Hold: out_valid & ~out_ready -> all out_* stable.
- Set and clear of the same busy bit in one cycle: set wins.
- wb_valid with wb_rd >= NUM_REGS: ignored.
- flush:
  - out_valid cleared next edge.
  - If the discarded entry wrote, its busy bit is cleared (unless the same edge also sets it).
  - No accept that cycle.
  - Busy bits of entries already consumed are untouched.
- flush & out_ready in the same cycle: flush wins; the entry is not considered consumed.

Decomposition:
- Shared package isa_pkg: opcode enum (OP_ADD..OP_ST), field slice constants, NUM_REGS, and a decoded-instruction struct (op, rs1, rs2, rd, reg_write, label_write, label_read, illegal).
- Sub-module scoreboard: busy vectors, set/clear/flush-clear logic, and the hazard output.
- Decode is a combinational function in isa_pkg.

Test Plan:
- Reset mid-stream with out_valid=1 and busy_g[2]=1 -> out_valid=0, busy cleared immediately; after rst_n rises, ADD rs=2 is accepted without stall.
- Stream ADD a0,a1 (0x001) then SUB a1,a0 (0x048) -> second stalls (busy_g[0]); in_ready=0 until wb_valid, wb_rd=0, wb_label=0, then it is accepted the same cycle.
- LBL l3,a1 (0x119) then JMP l3 (0x143) -> JMP stalls on busy_l[3]; out_label_read=1, out_rs1=3 after wb_label=1, wb_rd=3.
- Instruction 0x038 (rs=7) -> out_illegal=1, out_reg_write=0, no busy bit set; the next instruction is not stalled.
- out_ready=0 for 3 cycles with an entry held -> out_* stable, in_ready=0; out_ready=1 -> next instruction issues back-to-back.
- flush while the held entry is ADD a2 -> out_valid=0 next edge, busy_g[2]=0; a following read of a2 issues without stall.
